// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave/master state encoding and default word length.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam int unsigned SPI_D_WIDTH = 8;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to RST_VAL.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four cpol/cpha modes, MSB first, single-word tx buffer, continuous mode.
// Optional overrun detection with rx_ack strobe when SPI_SLAVE_OVR_EN is defined.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned D_WIDTH = SPI_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    input  logic [D_WIDTH-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               busy,
`ifdef SPI_SLAVE_OVR_EN
    input  logic               rx_ack,
`endif
    output logic               rx_ovr
);

    localparam int unsigned CW = $clog2(D_WIDTH);

    spi_state_e state, state_nxt;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_d, ss_d;
    logic [1:0] settle;
    logic armed;

    logic [CW-1:0]      bit_cnt;
    logic               fresh;
    logic [D_WIDTH-1:0] tx_shift;
    logic [D_WIDTH-2:0] rx_shift;
    logic [D_WIDTH-1:0] tx_buf;
    logic               buf_full;

    logic ss_fall, ss_rise, enter, active_ok;
    logic sclk_edge, lead, trail, sample, shift_evt;
    logic last_bit, word_done, reload, load_word, shift_en, tx_wr;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    spi_sync #(.RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst_n(rst_n), .d(ss_n), .q(ss_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

    // armed: after reset, ss_n must be seen high (synchroniser flushed) before a fall counts
    assign ss_fall   = ss_d & ~ss_s & armed;
    assign ss_rise   = ~ss_d & ss_s;
    assign enter     = (state == IDLE) & ss_fall;
    assign active_ok = (state == ACTIVE) & ~ss_rise;

    assign sclk_edge = sclk_s ^ sclk_d;
    assign lead      = sclk_edge & (sclk_s != cpol);
    assign trail     = sclk_edge & (sclk_s == cpol);
    assign sample    = active_ok & (cpha ? trail : lead);
    assign shift_evt = active_ok & (cpha ? lead : trail);

    // bit_cnt==0 at a shift edge: either the very first cpha=1 edge (MSB already out) or a word boundary
    assign last_bit  = (bit_cnt == CW'(D_WIDTH - 1));
    assign word_done = sample & last_bit;
    assign reload    = shift_evt & (bit_cnt == '0) & ~fresh;
    assign load_word = enter | reload;
    assign shift_en  = shift_evt & (bit_cnt != '0);
    assign tx_wr     = tx_valid & (~buf_full | load_word);
    assign tx_ready  = ~buf_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enter)   state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        miso    = 1'b0;
        miso_oe = 1'b0;
        busy    = 1'b0;
        if (state == ACTIVE) begin
            miso    = tx_shift[D_WIDTH-1];
            miso_oe = 1'b1;
            busy    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            ss_d   <= 1'b1;
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            ss_d   <= ss_s;
            if (settle != 2'd3) settle <= settle + 2'd1;
            armed  <= armed | ((settle == 2'd3) & ss_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            fresh    <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            tx_buf   <= '0;
            buf_full <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (tx_wr) tx_buf <= tx_data;
            buf_full <= tx_wr | (buf_full & ~load_word);

            if (enter) begin
                bit_cnt <= '0;
                fresh   <= 1'b1;
            end else if (sample) begin
                fresh    <= 1'b0;
                rx_shift <= {rx_shift[D_WIDTH-3:0], mosi_s};
                if (last_bit) begin
                    bit_cnt  <= '0;
                    rx_data  <= {rx_shift, mosi_s};
                    rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (load_word)     tx_shift <= buf_full ? tx_buf : '0;
            else if (shift_en) tx_shift <= {tx_shift[D_WIDTH-2:0], 1'b0};
        end
    end

`ifdef SPI_SLAVE_OVR_EN
    logic rx_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pending <= 1'b0;
            rx_ovr     <= 1'b0;
        end else begin
            rx_pending <= (rx_pending & ~rx_ack) | word_done;
            if (word_done & rx_pending & ~rx_ack) rx_ovr <= 1'b1;
        end
    end
`else
    assign rx_ovr = 1'b0;
`endif

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, giving the word length in bits (range 4..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock; all logic is sampled on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cpol, input, 1 bit: SPI clock idle level; static while ss_n is low.
REQ-005 The block SHALL have port cpha, input, 1 bit: SPI clock phase; static while ss_n is low.
REQ-006 The block SHALL have port sclk, input, 1 bit: SPI clock from the master, asynchronous to clk.
REQ-007 The block SHALL have port ss_n, input, 1 bit: slave select, active low, asynchronous to clk.
REQ-008 The block SHALL have port mosi, input, 1 bit: serial data from the master.
REQ-009 The block SHALL have port miso, output, 1 bit: serial data to the master.
REQ-010 The block SHALL have port miso_oe, output, 1 bit: miso drive enable; the top level tristates miso when it is 0.
REQ-011 The block SHALL have port tx_data, input, D_WIDTH bits: the next word to transmit.
REQ-012 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-013 The block SHALL have port tx_ready, output, 1 bit: the transmit buffer is empty.
REQ-014 The block SHALL have port rx_data, output, D_WIDTH bits: the last complete received word.
REQ-015 The block SHALL have port rx_valid, output, 1 bit: one-clk pulse marking a new rx_data.
REQ-016 The block SHALL have port busy, output, 1 bit: high while selected (synchronised ss_n is low).
REQ-017 The block SHALL have port rx_ovr, output, 1 bit: sticky overrun flag.

Function
REQ-018 sclk, ss_n and mosi SHALL each pass through a 2-flop synchroniser; edges are detected on the synchronised values, and clk frequency SHALL be at least 4x sclk.
REQ-019 The state machine SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on synchronised ss_n falling, ACTIVE->IDLE on synchronised ss_n rising.
REQ-020 Leading edge = sclk leaving cpol; trailing edge = sclk returning to cpol.
REQ-021 cpha=0: sample mosi on the leading edge, shift miso on the trailing edge.
REQ-022 cpha=1: shift miso on the leading edge, sample mosi on the trailing edge.
REQ-023 Data SHALL be sent and received MSB first.
REQ-024 On ACTIVE entry: load the shift register from the tx buffer, or with all-zeros if the buffer is empty; clear the bit counter; miso = MSB; miso_oe=1.
REQ-025 tx handshake: the buffer SHALL be written when tx_valid&&tx_ready; tx_ready SHALL rise the cycle after the buffer is consumed by a word load.
REQ-026 After the D_WIDTH-th sample: rx_data SHALL update and rx_valid SHALL pulse for 1 clk, exactly 3 clk rising edges after the sampling sclk edge reaches the synchroniser input.
REQ-027 The bit counter SHALL wrap to 0; if ss_n is still low, the next word is reloaded from the buffer (continuous mode) with no gap bit.
REQ-028 ss_n rising mid-word SHALL abort the transfer: the partial word is discarded, there is no rx_valid, the buffer is untouched, and miso_oe=0 the next clk.
REQ-029 In IDLE, sclk edges SHALL be ignored.
REQ-030 A tx_valid arriving in the same cycle as a word load SHALL be accepted into the (now empty) buffer.

Reset
REQ-031 While rst_n=0: state IDLE, miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, rx_ovr=0, and synchronisers set to idle levels (ss_n=1, sclk=0).
REQ-032 Assertion of rst_n mid-transfer SHALL abort immediately; the block resumes only on a fresh ss_n falling edge after release.

Configuration
REQ-033 With SPI_SLAVE_OVR_EN defined, rx_ovr SHALL set when a new word completes while rx_valid from the previous word was not acknowledged via a rx_ack strobe (extra 1-bit input, present only with the macro) and SHALL clear on reset only.
REQ-034 Without SPI_SLAVE_OVR_EN, rx_ovr SHALL be tied to 0 and rx_ack SHALL be absent.

Structure
REQ-035 The state enum and the default D_WIDTH SHALL reside in package spi_pkg, shared with spi_master.
REQ-036 The 2-flop synchroniser SHALL be the sub-module spi_sync, instantiated three times.

Verification
REQ-037 Mode 3 (cpol=1, cpha=1), tx 0x1D preloaded, master sends 0x55 -> master receives 0x1D, rx_data=0x55, one rx_valid pulse.
REQ-038 Mode 0, continuous: two words 0xA5, 0x3C with ss_n held low, buffer refilled with 0x01 -> two rx_valid pulses, miso carries 0x1D then 0x01.
REQ-039 Empty buffer at ss_n fall -> miso all zeros, tx_ready stays 1.
REQ-040 ss_n released after 5 bits -> no rx_valid, rx_data unchanged, miso_oe=0.
REQ-041 rst_n pulsed low mid-word -> all outputs at reset values; the next full transfer of 0x55 completes correctly.
REQ-042 SPI_SLAVE_OVR_EN defined, two words with no rx_ack -> rx_ovr=1 after the second rx_valid.
